fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_pkg.sv | 49 ++++
 rtl/fir_coef_bank.sv | 57 +++++
 rtl/fir_filter_param.sv | 118 +++++++++++
 tb/tb_fir_filter_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the parameterised FIR filter.
package fir_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_COEF_W    = 16;
   localparam int DEF_TAPS      = 8;
   localparam int DEF_OUT_SHIFT = 15;

   // Helpers work on fixed wide containers; callers sign-extend in and slice out.
   localparam int ACC_MAX = 128;
   localparam int Y_MAX   = 64;

   typedef struct packed {
      logic                    sat;
      logic signed [Y_MAX-1:0] y;
   } rs_t;

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   function automatic rs_t round_sat(input logic signed [ACC_MAX-1:0] acc,
                                     input int shift,
                                     input int data_w);
      logic signed [ACC_MAX-1:0] one_v;
      logic signed [ACC_MAX-1:0] rnd_v;
      logic signed [ACC_MAX-1:0] shr_v;
      logic signed [ACC_MAX-1:0] max_v;
      logic signed [ACC_MAX-1:0] min_v;
      rs_t                       res;
      one_v = {{(ACC_MAX-1){1'b0}}, 1'b1};
      rnd_v = acc + (one_v <<< (shift - 1));
      shr_v = rnd_v >>> shift;
      max_v = (one_v <<< (data_w - 1)) - one_v;
      min_v = -(one_v <<< (data_w - 1));
      if (shr_v > max_v) begin
         res.sat = 1'b1;
         res.y   = max_v[Y_MAX-1:0];
      end else if (shr_v < min_v) begin
         res.sat = 1'b1;
         res.y   = min_v[Y_MAX-1:0];
      end else begin
         res.sat = 1'b0;
         res.y   = shr_v[Y_MAX-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: writes land in the shadow bank,
// commit copies the shadow bank (including a same-edge write) to the active bank.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int TAPS   = DEF_TAPS,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ADDR_W = $clog2(DEF_TAPS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         coef_we,
   input  logic [ADDR_W-1:0]            coef_addr,
   input  logic [COEF_W-1:0]            coef_data,
   input  logic                         coef_commit,
   output logic [TAPS-1:0][COEF_W-1:0]  coef_act
);

   logic [TAPS-1:0][COEF_W-1:0] shadow_r;
   logic [TAPS-1:0][COEF_W-1:0] shadow_nxt_s;
   logic [TAPS-1:0][COEF_W-1:0] active_r;
   logic                        addr_ok_s;

   generate
      if ((1 << ADDR_W) == TAPS) begin : g_pow2
         assign addr_ok_s = 1'b1;
      end else begin : g_npow2
         assign addr_ok_s = (32'(coef_addr) < 32'(TAPS));
      end
   endgenerate

   // Shadow bank next value with any legal write applied.
   always_comb begin
      shadow_nxt_s = shadow_r;
      if (coef_we && addr_ok_s) begin
         shadow_nxt_s[coef_addr] = coef_data;
      end else begin
         shadow_nxt_s = shadow_r;
      end
   end

   // Shadow and active bank registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_r <= '0;
         active_r <= '0;
      end else begin
         shadow_r <= shadow_nxt_s;
         if (coef_commit) begin
            active_r <= shadow_nxt_s;
         end
      end
   end

   assign coef_act = active_r;

endmodule

// File: rtl/fir_filter_param.sv
// Parameterised direct-form FIR: registered products at the accept edge,
// then sum, round and saturate into the registered output one edge later.
module fir_filter_param
   import fir_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int COEF_W    = DEF_COEF_W,
   parameter int TAPS      = DEF_TAPS,
   parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          x_in,
   input  logic                       coef_we,
   input  logic [$clog2(TAPS)-1:0]    coef_addr,
   input  logic [COEF_W-1:0]          coef_data,
   input  logic                       coef_commit,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          y_out,
   output logic                       sat
);

   localparam int ADDR_W = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

   logic [TAPS-1:0][COEF_W-1:0]  coef_act_s;
   logic signed [DATA_W-1:0]     hist_r [TAPS-1];
   logic signed [DATA_W-1:0]     tap_s  [TAPS];
   logic signed [PROD_W-1:0]     prod_r [TAPS];
   logic                         p_valid_r;
   logic signed [ACC_W-1:0]      acc_s;
   logic signed [ACC_MAX-1:0]    acc_ext_s;
   rs_t                          rs_s;
   logic                         unused_s;
   logic                         out_valid_r;
   logic [DATA_W-1:0]            y_out_r;
   logic                         sat_r;

   fir_coef_bank #(
      .TAPS   (TAPS),
      .COEF_W (COEF_W),
      .ADDR_W (ADDR_W)
   ) u_coef_bank (
      .clk         (clk),
      .rst         (rst),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_commit (coef_commit),
      .coef_act    (coef_act_s)
   );

   // Tap k sees x[n-k]: the incoming sample, then the stored history.
   always_comb begin
      tap_s[0] = $signed(x_in);
      for (int k = 1; k < TAPS; k++) begin
         tap_s[k] = hist_r[k-1];
      end
   end

   // Delay line and product stage advance only on accepted samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS-1; k++) begin
            hist_r[k] <= '0;
         end
         for (int k = 0; k < TAPS; k++) begin
            prod_r[k] <= '0;
         end
         p_valid_r <= 1'b0;
      end else begin
         p_valid_r <= in_valid;
         if (in_valid) begin
            for (int k = 0; k < TAPS-1; k++) begin
               hist_r[k] <= tap_s[k];
            end
            for (int k = 0; k < TAPS; k++) begin
               prod_r[k] <= PROD_W'($signed(coef_act_s[k])) * PROD_W'(tap_s[k]);
            end
         end
      end
   end

   // Adder tree, widened so the full sum never wraps.
   always_comb begin
      acc_s = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc_s = acc_s + ACC_W'(prod_r[k]);
      end
      acc_ext_s = ACC_MAX'(acc_s);
      rs_s      = round_sat(acc_ext_s, OUT_SHIFT, DATA_W);
   end

   // Upper bits of the helper result are sign copies once saturated to DATA_W.
   assign unused_s = ^rs_s.y[Y_MAX-1:DATA_W];

   // Output stage holds its value between results.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         y_out_r     <= '0;
         sat_r       <= 1'b0;
      end else begin
         out_valid_r <= p_valid_r;
         if (p_valid_r) begin
            y_out_r <= rs_s.y[DATA_W-1:0];
            sat_r   <= rs_s.sat;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign y_out     = y_out_r;
   assign sat       = sat_r;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench: directed vector tables plus randomized traffic against a behavioural model.
module tb_fir_filter_param;

   localparam int DATA_W    = 16;
   localparam int COEF_W    = 16;
   localparam int TAPS      = 8;
   localparam int OUT_SHIFT = 15;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic signed [DATA_W-1:0] x_in;
   logic                     coef_we;
   logic [2:0]               coef_addr;
   logic [COEF_W-1:0]        coef_data;
   logic                     coef_commit;
   logic                     out_valid;
   logic [DATA_W-1:0]        y_out;
   logic                     sat;

   always #5 clk = ~clk;

   fir_filter_param #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_commit(coef_commit), .out_valid(out_valid), .y_out(y_out), .sat(sat)
   );

   typedef struct { int due; int y; int s; } exp_t;
   typedef struct { int y; int s; } obs_t;
   typedef struct { int x; bit chk; int y; int s; } vec_t;

   exp_t   exp_q[$];
   obs_t   got_q[$];
   int     n_checks = 0;
   int     n_fail = 0;
   int     cyc = 0;
   longint hist_m [TAPS];
   longint act_m  [TAPS];
   longint shd_m  [TAPS];
   int     last_y = 0;
   int     last_s = 0;

   function automatic void check(string name, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // y[n] = sat(round(sum c[k]*x[n-k] >>> OUT_SHIFT)) on plain integers.
   function automatic void model_accept(longint x);
      longint acc;
      longint r;
      int     y;
      int     s;
      for (int k = TAPS-1; k > 0; k--) hist_m[k] = hist_m[k-1];
      hist_m[0] = x;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += act_m[k] * hist_m[k];
      r = (acc + (64'sd1 <<< (OUT_SHIFT-1))) >>> OUT_SHIFT;
      if (r > 32767) begin
         y = 32767; s = 1;
      end else if (r < -32768) begin
         y = -32768; s = 1;
      end else begin
         y = int'(r); s = 0;
      end
      exp_q.push_back('{due: cyc + 1, y: y, s: s});
   endfunction

   task automatic step(input bit r, input bit v, input int x,
                       input bit we = 1'b0, input int a = 0, input int d = 0,
                       input bit cm = 1'b0);
      longint nsh [TAPS];
      bit     exp_v;
      @(negedge clk);
      rst = r; in_valid = v; x_in = 16'(x);
      coef_we = we; coef_addr = 3'(a); coef_data = 16'(d); coef_commit = cm;
      @(posedge clk);
      cyc++;
      if (r) begin
         for (int k = 0; k < TAPS; k++) begin
            hist_m[k] = 0; act_m[k] = 0; shd_m[k] = 0;
         end
         exp_q.delete();
         last_y = 0; last_s = 0;
      end else begin
         nsh = shd_m;
         if (we && a < TAPS) nsh[a] = d;
         if (v) model_accept(x);
         if (cm) act_m = nsh;
         shd_m = nsh;
      end
      #1;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
         last_y = exp_q[0].y; last_s = exp_q[0].s;
         void'(exp_q.pop_front());
      end
      if (out_valid) got_q.push_back('{y: int'($signed(y_out)), s: int'(sat)});
      check("y_out", longint'($signed(y_out)), last_y);
      check("sat", sat, last_s);
   endtask

   // Write every shadow slot; commit rides on the last write.
   task automatic load_coefs(input longint c [TAPS]);
      for (int k = 0; k < TAPS; k++) step(1'b0, 1'b0, 0, 1'b1, k, int'(c[k]), k == TAPS-1);
   endtask

   task automatic run_vectors(input string name, input vec_t v[$]);
      got_q.delete();
      foreach (v[i]) step(1'b0, 1'b1, v[i].x);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      check({name, "_count"}, got_q.size(), v.size());
      for (int i = 0; i < v.size() && i < got_q.size(); i++) begin
         if (v[i].chk) begin
            check({name, "_y"}, got_q[i].y, v[i].y);
            check({name, "_sat"}, got_q[i].s, v[i].s);
         end
      end
   endtask

   initial begin
      vec_t   imp_v[$];
      vec_t   stp_v[$];
      vec_t   sp_v[$];
      vec_t   sn_v[$];
      longint c_imp [TAPS];
      longint c_stp [TAPS];
      longint c_sat [TAPS];
      longint c_rnd [TAPS];
      longint c_a   [TAPS];
      int     xs[$];
      obs_t   ref_q[$];

      rst = 1'b1; in_valid = 1'b0; x_in = '0; coef_we = 1'b0;
      coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
      for (int k = 0; k < TAPS; k++) begin
         hist_m[k] = 0; act_m[k] = 0; shd_m[k] = 0;
         c_imp[k] = 0; c_stp[k] = 0; c_sat[k] = 32767; c_a[k] = 0;
      end
      c_imp[0] = 16384; c_imp[1] = 8192; c_imp[2] = -8192;
      c_stp[0] = 16384; c_stp[1] = 16384;
      c_a[0]   = 16384;

      imp_v.push_back('{x: 20000, chk: 1'b1, y: 10000, s: 0});
      imp_v.push_back('{x: 0, chk: 1'b1, y: 5000, s: 0});
      imp_v.push_back('{x: 0, chk: 1'b1, y: -5000, s: 0});
      for (int i = 0; i < 4; i++) imp_v.push_back('{x: 0, chk: 1'b1, y: 0, s: 0});
      for (int i = 0; i < 16; i++) stp_v.push_back('{x: 10000, chk: 1'b1, y: (i == 0) ? 5000 : 10000, s: 0});
      for (int i = 0; i < 10; i++) sp_v.push_back('{x: 32767, chk: 1'b1, y: (i == 0) ? 32766 : 32767, s: (i == 0) ? 0 : 1});
      for (int i = 0; i < 10; i++) sn_v.push_back('{x: -32768, chk: 1'b1, y: (i == 0) ? -32767 : -32768, s: (i == 0) ? 0 : 1});

      // Reset state, with stimulus present to show reset priority.
      step(1'b1, 1'b1, 1234, 1'b1, 0, 999, 1'b1);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);

      load_coefs(c_imp); run_vectors("impulse", imp_v);
      step(1'b1, 1'b0, 0); load_coefs(c_stp); run_vectors("step", stp_v);
      step(1'b1, 1'b0, 0); load_coefs(c_sat); run_vectors("sat_pos", sp_v);
      step(1'b1, 1'b0, 0); load_coefs(c_sat); run_vectors("sat_neg", sn_v);

      // Gap-free reference run, then the same samples with idle cycles between.
      for (int k = 0; k < TAPS; k++) c_rnd[k] = longint'(int'($urandom_range(0, 65535)) - 32768);
      for (int i = 0; i < 20; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
      step(1'b1, 1'b0, 0); load_coefs(c_rnd);
      got_q.delete();
      foreach (xs[i]) step(1'b0, 1'b1, xs[i]);
      step(1'b0, 1'b0, 0); step(1'b0, 1'b0, 0);
      ref_q = got_q;
      step(1'b1, 1'b0, 0); load_coefs(c_rnd);
      got_q.delete();
      foreach (xs[i]) begin
         step(1'b0, 1'b1, xs[i]);
         step(1'b0, 1'b0, 0);
      end
      step(1'b0, 1'b0, 0);
      check("gapped_count", got_q.size(), ref_q.size());
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
         check("gapped_y", got_q[i].y, ref_q[i].y);
      end

      // Bank swap on the same edge as a sample.
      step(1'b1, 1'b0, 0); load_coefs(c_a);
      step(1'b0, 1'b0, 0, 1'b1, 0, -16384);
      got_q.delete();
      step(1'b0, 1'b1, 1000);
      step(1'b0, 1'b1, 3000, 1'b0, 0, 0, 1'b1);
      step(1'b0, 1'b1, 2000);
      step(1'b0, 1'b0, 0); step(1'b0, 1'b0, 0);
      check("swap_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("swap_old0", got_q[0].y, 500);
         check("swap_old1", got_q[1].y, 1500);
         check("swap_new", got_q[2].y, -1000);
      end

      // Reset one cycle after an accept discards that sample.
      step(1'b1, 1'b0, 0); load_coefs(c_imp);
      got_q.delete();
      step(1'b0, 1'b1, 20000);
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
      check("rst_drop", got_q.size(), 0);
      load_coefs(c_imp); run_vectors("post_rst_impulse", imp_v);

      // Randomized traffic checked cycle by cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 199) == 0, ($urandom % 4) != 0,
              int'($urandom_range(0, 65535)) - 32768,
              ($urandom % 3) == 0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 65535)) - 32768, ($urandom % 16) == 0);
      end
      step(1'b0, 1'b0, 0); step(1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
